// File: rtl/sram_port_arbiter.sv
// Two-port (fetch/data) controller for BANKS asynchronous SRAM chips.
// IDLE -> ACCESS (WAIT+1 strobe cycles) -> DONE (ready pulse, write hold) -> IDLE.
`timescale 1ns/1ps
module sram_port_arbiter #(
    parameter int ADDR_W = 20,
    parameter int BANKS  = 2,
    parameter int WAIT   = 1,
    parameter int FAIR   = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_req,
    input  logic [31:0]              i_addr,
    output logic [31:0]              i_rdata,
    output logic                     i_ready,
    input  logic                     d_req,
    input  logic                     d_we,
    input  logic [3:0]               d_be,
    input  logic [31:0]              d_addr,
    input  logic [31:0]              d_wdata,
    output logic [31:0]              d_rdata,
    output logic                     d_ready,
    output logic                     busy,
    inout  wire  [32*BANKS-1:0]      ram_data,
    output logic [ADDR_W*BANKS-1:0]  ram_addr,
    output logic [4*BANKS-1:0]       ram_be_n,
    output logic [BANKS-1:0]         ram_ce_n,
    output logic [BANKS-1:0]         ram_oe_n,
    output logic [BANKS-1:0]         ram_we_n,
    output logic [1:0]               dbg_state_o
);
    localparam int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    logic [1:0]              state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    port_q;   // owner of the transaction: 1 = data, 0 = fetch
    logic                    last_q;
    logic                    we_q;
    logic [BANKS-1:0]        sel_q;
    logic [31:0]             wdata_q;
    logic [31:0]             i_rdata_q, d_rdata_q;
    logic [ADDR_W*BANKS-1:0] addr_q;
    logic [4*BANKS-1:0]      be_n_q;
    logic [BANKS-1:0]        ce_n_q, oe_n_q, we_n_q, drive_q;

    logic                    win, pick_data, req_we, last_access;
    logic [31:0]             req_addr, bus_rd;
    logic [BANK_W-1:0]       req_bank;
    logic [BANKS-1:0]        req_oh;
    logic                    unused_addr;

    // Ties go to the port that did not win last time when FAIR is set.
    always_comb begin
        pick_data = d_req;
        if (FAIR != 0 && i_req && d_req) pick_data = ~last_q;
    end

    assign win         = i_req | d_req;
    assign req_addr    = pick_data ? d_addr : i_addr;
    assign req_we      = pick_data & d_we;
    assign unused_addr = ^req_addr;

    if (BANKS > 1) begin : g_bank
        assign req_bank = req_addr[ADDR_W+2 +: BANK_W];
    end else begin : g_one_bank
        assign req_bank = '0;
    end

    assign req_oh = BANKS'(1) << req_bank;

    always_comb begin
        bus_rd = '0;
        for (int b = 0; b < BANKS; b++) begin
            if (sel_q[b]) bus_rd = ram_data[b*32 +: 32];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (win) begin
                    state_d = S_ACCESS;
                    cnt_d   = 4'(WAIT);
                end
            end
            S_ACCESS: begin
                if (cnt_q == 4'd0) state_d = S_DONE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign last_access = (state_q == S_ACCESS) && (cnt_q == 4'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            port_q    <= 1'b0;
            last_q    <= 1'b0;
            we_q      <= 1'b0;
            sel_q     <= '0;
            wdata_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            addr_q    <= '0;
            be_n_q    <= '1;
            ce_n_q    <= '1;
            oe_n_q    <= '1;
            we_n_q    <= '1;
            drive_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == S_IDLE && win) begin
                port_q  <= pick_data;
                last_q  <= pick_data;
                we_q    <= req_we;
                sel_q   <= req_oh;
                wdata_q <= d_wdata;
                for (int b = 0; b < BANKS; b++) begin
                    if (req_oh[b]) begin
                        addr_q[b*ADDR_W +: ADDR_W] <= req_addr[ADDR_W+1:2];
                        be_n_q[b*4 +: 4]           <= req_we ? ~d_be : 4'b0000;
                    end
                end
                ce_n_q  <= ~req_oh;
                oe_n_q  <= req_we ? '1 : ~req_oh;
                we_n_q  <= req_we ? ~req_oh : '1;
                drive_q <= req_we ? req_oh : '0;
            end else if (last_access) begin
                if (!we_q) begin
                    if (port_q) d_rdata_q <= bus_rd;
                    else        i_rdata_q <= bus_rd;
                    ce_n_q <= '1;
                end
                // Writes keep ce_n low and the bus driven through DONE for hold time.
                oe_n_q <= '1;
                we_n_q <= '1;
                be_n_q <= '1;
            end else if (state_q == S_DONE) begin
                ce_n_q  <= '1;
                drive_q <= '0;
            end
        end
    end

    for (genvar b = 0; b < BANKS; b++) begin : g_bus
        assign ram_data[b*32 +: 32] = drive_q[b] ? wdata_q : 32'bz;
    end

    assign ram_addr    = addr_q;
    assign ram_be_n    = be_n_q;
    assign ram_ce_n    = ce_n_q;
    assign ram_oe_n    = oe_n_q;
    assign ram_we_n    = we_n_q;
    assign i_rdata     = i_rdata_q;
    assign d_rdata     = d_rdata_q;
    assign i_ready     = (state_q == S_DONE) && !port_q;
    assign d_ready     = (state_q == S_DONE) && port_q;
    assign busy        = (state_q != S_IDLE);
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench: dut0 (WAIT=1, fixed priority) and dut1 (WAIT=0, round-robin)
// share stimulus; each has its own two-bank SRAM model.
`timescale 1ns/1ps
module tb_sram_port_arbiter;
    logic        clk = 1'b0;
    logic        rst, load_mem;
    logic        i_req, d_req, d_we;
    logic [3:0]  d_be;
    logic [31:0] i_addr, d_addr, d_wdata;

    logic [31:0] i_rdata0, d_rdata0, i_rdata1, d_rdata1;
    logic        i_ready0, d_ready0, busy0, i_ready1, d_ready1, busy1;
    wire  [63:0] ram_data0, ram_data1;
    logic [39:0] ram_addr0, ram_addr1;
    logic [7:0]  be_n0, be_n1;
    logic [1:0]  ce_n0, oe_n0, we_n0, ce_n1, oe_n1, we_n1, st0, st1;

    logic [31:0] mem0 [0:1][0:15];
    logic [31:0] mem1 [0:1][0:15];

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_i, exp_d;

    typedef struct {
        logic        port;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        bank;
        logic [19:0] word;
        logic [3:0]  be_n;
        logic [31:0] rdata;
    } vec_t;
    vec_t vecs [9];

    always #5 clk = ~clk;

    sram_port_arbiter #(.ADDR_W(20), .BANKS(2), .WAIT(1), .FAIR(0)) dut0 (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata0), .i_ready(i_ready0),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata0), .d_ready(d_ready0), .busy(busy0),
        .ram_data(ram_data0), .ram_addr(ram_addr0), .ram_be_n(be_n0),
        .ram_ce_n(ce_n0), .ram_oe_n(oe_n0), .ram_we_n(we_n0), .dbg_state_o(st0)
    );

    sram_port_arbiter #(.ADDR_W(20), .BANKS(2), .WAIT(0), .FAIR(1)) dut1 (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata1), .i_ready(i_ready1),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata1), .d_ready(d_ready1), .busy(busy1),
        .ram_data(ram_data1), .ram_addr(ram_addr1), .ram_be_n(be_n1),
        .ram_ce_n(ce_n1), .ram_oe_n(oe_n1), .ram_we_n(we_n1), .dbg_state_o(st1)
    );

    // Asynchronous SRAM models: drive the bus while selected and output-enabled.
    for (genvar b = 0; b < 2; b++) begin : g_sram
        assign ram_data0[b*32 +: 32] = (!ce_n0[b] && !oe_n0[b]) ? mem0[b][ram_addr0[b*20 +: 4]] : 32'bz;
        assign ram_data1[b*32 +: 32] = (!ce_n1[b] && !oe_n1[b]) ? mem1[b][ram_addr1[b*20 +: 4]] : 32'bz;
    end

    always @(posedge clk) begin
        if (load_mem) begin
            for (int b = 0; b < 2; b++) begin
                for (int w = 0; w < 16; w++) begin
                    mem0[b][w] <= 32'h0;
                    mem1[b][w] <= 32'h0;
                end
            end
            mem0[0][4] <= 32'h2402_0005;  mem1[0][4] <= 32'h2402_0005;
            mem0[1][2] <= 32'h1122_3344;  mem1[1][2] <= 32'h1122_3344;
            mem0[1][0] <= 32'h0102_0304;  mem1[1][0] <= 32'h0102_0304;
        end else begin
            for (int b = 0; b < 2; b++) begin
                for (int j = 0; j < 4; j++) begin
                    if (!ce_n0[b] && !we_n0[b] && !be_n0[b*4+j])
                        mem0[b][ram_addr0[b*20 +: 4]][j*8 +: 8] <= ram_data0[b*32+j*8 +: 8];
                    if (!ce_n1[b] && !we_n1[b] && !be_n1[b*4+j])
                        mem1[b][ram_addr1[b*20 +: 4]][j*8 +: 8] <= ram_data1[b*32+j*8 +: 8];
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic reset_pulse();
        i_req = 1'b0;
        d_req = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
    endtask

    // One transaction on dut0, request presented at the current negedge (cycle 0).
    task automatic run_vec(input int k, input vec_t v);
        int bk;
        bk = int'(v.bank);
        if (v.port) begin
            d_req = 1'b1; d_we = v.we; d_be = v.be; d_addr = v.addr; d_wdata = v.wdata;
        end else begin
            i_req = 1'b1; i_addr = v.addr;
        end
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (c < 3) begin
                check($sformatf("v%0d_c%0d_ce", k, c), ce_n0, bk != 0 ? 2'b01 : 2'b10);
                check($sformatf("v%0d_c%0d_addr", k, c), ram_addr0[bk*20 +: 20], v.word);
                check($sformatf("v%0d_c%0d_be_n", k, c), be_n0, bk != 0 ? {v.be_n, 4'hF} : {4'hF, v.be_n});
                check($sformatf("v%0d_c%0d_oe", k, c), oe_n0, v.we ? 2'b11 : (bk != 0 ? 2'b01 : 2'b10));
                check($sformatf("v%0d_c%0d_we", k, c), we_n0, v.we ? (bk != 0 ? 2'b01 : 2'b10) : 2'b11);
                check($sformatf("v%0d_c%0d_rdy", k, c), {i_ready0, d_ready0}, 2'b00);
            end else begin
                check($sformatf("v%0d_done_rdy", k), {i_ready0, d_ready0}, v.port ? 2'b01 : 2'b10);
                check($sformatf("v%0d_done_strobes", k), {oe_n0, we_n0, be_n0}, 12'hFFF);
                check($sformatf("v%0d_done_ce", k), ce_n0, v.we ? (bk != 0 ? 2'b01 : 2'b10) : 2'b11);
            end
            if (v.we) check($sformatf("v%0d_c%0d_bus", k, c), ram_data0[bk*32 +: 32], v.wdata);
            if (c == 1) begin
                i_addr = $urandom; d_addr = $urandom; d_wdata = $urandom;
            end
        end
        i_req = 1'b0;
        d_req = 1'b0;
        if (!v.we) begin
            if (v.port) exp_d = v.rdata;
            else        exp_i = v.rdata;
        end
        @(negedge clk);
        check($sformatf("v%0d_i_rdata", k), i_rdata0, exp_i);
        check($sformatf("v%0d_d_rdata", k), d_rdata0, exp_d);
        check($sformatf("v%0d_idle", k), busy0, 1'b0);
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b0, 4'b0000, 32'h8000_0010, 32'h0,         1'b0, 20'h4, 4'b0000, 32'h2402_0005};
        vecs[1] = '{1'b1, 1'b1, 4'b0011, 32'h8040_0008, 32'hAABB_CCDD, 1'b1, 20'h2, 4'b1100, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 4'b0000, 32'h8040_0008, 32'h0,         1'b1, 20'h2, 4'b0000, 32'h1122_CCDD};
        vecs[3] = '{1'b1, 1'b1, 4'b1111, 32'hF000_003C, 32'hDEAD_BEEF, 1'b0, 20'hF, 4'b0000, 32'h0};
        vecs[4] = '{1'b1, 1'b0, 4'b0000, 32'h0000_003F, 32'h0,         1'b0, 20'hF, 4'b0000, 32'hDEAD_BEEF};
        vecs[5] = '{1'b1, 1'b1, 4'b1000, 32'h0040_0000, 32'h5A00_0000, 1'b1, 20'h0, 4'b0111, 32'h0};
        vecs[6] = '{1'b0, 1'b0, 4'b0000, 32'h0040_0001, 32'h0,         1'b1, 20'h0, 4'b0000, 32'h5A02_0304};
        vecs[7] = '{1'b1, 1'b1, 4'b0100, 32'h8000_0010, 32'h0077_0000, 1'b0, 20'h4, 4'b1011, 32'h0};
        vecs[8] = '{1'b0, 1'b0, 4'b0000, 32'h8000_0010, 32'h0,         1'b0, 20'h4, 4'b0000, 32'h2477_0005};

        rst = 1'b1; load_mem = 1'b1;
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_be = 4'h0;
        i_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0;
        exp_i = 32'h0; exp_d = 32'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0; load_mem = 1'b0;

        // Reset state
        check("rst0_strobes", {ce_n0, oe_n0, we_n0, be_n0}, 14'h3FFF);
        check("rst0_addr", ram_addr0, 40'h0);
        check("rst0_status", {busy0, i_ready0, d_ready0, st0}, 5'b0);
        check("rst0_rdata", {i_rdata0, d_rdata0}, 64'h0);
        check("rst1_strobes", {ce_n1, oe_n1, we_n1, be_n1}, 14'h3FFF);
        check("rst1_status", {busy1, i_ready1, d_ready1, st1}, 5'b0);

        // Single transactions, byte writes, address decode, rdata stability
        for (int k = 0; k < 9; k++) run_vec(k, vecs[k]);

        // Both ports held: dut0 always grants data, dut1 alternates
        reset_pulse();
        i_req = 1'b1; i_addr = 32'h8000_0010;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8040_0008;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            check($sformatf("prio_d_c%0d", c), d_ready0, (c == 3 || c == 7 || c == 11));
            check($sformatf("prio_i_c%0d", c), i_ready0, (c == 15));
            check($sformatf("fair_d_c%0d", c), d_ready1, (c == 2 || c == 8));
            check($sformatf("fair_i_c%0d", c), i_ready1, (c == 5 || c == 11 || c == 14));
            if (c == 12) d_req = 1'b0;
        end
        i_req = 1'b0;
        @(negedge clk);
        check("prio_rdata0", {i_rdata0, d_rdata0}, {32'h2477_0005, 32'h1122_CCDD});
        check("fair_rdata1", {i_rdata1, d_rdata1}, {32'h2477_0005, 32'h1122_CCDD});

        // Reset in the last strobe cycle of a dut0 fetch
        reset_pulse();
        i_req = 1'b1; i_addr = 32'h8000_0010;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            case (c)
                1, 2: begin
                    check($sformatf("rstmid_oe_c%0d", c), oe_n0, 2'b10);
                    if (c == 2) rst = 1'b1;
                end
                3: begin
                    check("rstmid_rdy", {i_ready0, d_ready0}, 2'b00);
                    check("rstmid_strobes", {ce_n0, oe_n0, we_n0, be_n0}, 14'h3FFF);
                    check("rstmid_addr", ram_addr0, 40'h0);
                    check("rstmid_state", {busy0, st0}, 3'b0);
                    check("rstmid_rdata", i_rdata0, 32'h0);
                    rst = 1'b0;
                end
                4, 5: begin
                    check($sformatf("rstmid_re_ce_c%0d", c), ce_n0, 2'b10);
                    check($sformatf("rstmid_re_rdy_c%0d", c), i_ready0, 1'b0);
                end
                6: begin
                    check("rstmid_re_rdy", i_ready0, 1'b1);
                    i_req = 1'b0;
                end
                default: check("rstmid_re_rdata", i_rdata0, 32'h2477_0005);
            endcase
        end

        // Back-to-back alternating write/read on dut1 (WAIT=0)
        reset_pulse();
        d_req = 1'b1; d_we = 1'b1; d_be = 4'b1111; d_addr = 32'h0000_0014; d_wdata = 32'h1111_1111;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            check($sformatf("b2b_rdy_c%0d", c), {i_ready1, d_ready1}, {1'b0, (c % 3 == 2)});
            check($sformatf("b2b_oewe1_c%0d", c), oe_n1 | we_n1, 2'b11);
            check($sformatf("b2b_oewe0_c%0d", c), oe_n0 | we_n0, 2'b11);
            if (c == 2 || c == 8) d_we = 1'b0;
            if (c == 5) begin
                check("b2b_read1", d_rdata1, 32'h1111_1111);
                d_we = 1'b1; d_be = 4'b0001; d_wdata = 32'h2222_2222;
            end
            if (c == 11) begin
                check("b2b_read2", d_rdata1, 32'h1111_1122);
                d_req = 1'b0;
            end
        end
        @(negedge clk);
        check("b2b_idle", busy1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
